// File: rtl/hwpe_ctrl_ctx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_ctx_scheduler
// Description : Job-context scheduler for an HWPE controller. Software takes
//               an offload lock with a test-and-set acquire, programs the
//               context at pointer_context_o, and commits it with a trigger
//               from the same requester ID. Committed jobs are started on the
//               engine in order. Each engine done pulse retires one job.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_CONTEXT          number of job contexts (2..4)
//   ID_WIDTH           requester ID width
//   CW                 context index width, max(1, clog2(N_CONTEXT))
// Ports
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   clear_i            synchronous soft clear, returns to the reset state
//   acquire_i          one-cycle acquire (test-and-set of the lock)
//   acquire_src_i      requester ID of the acquire
//   trigger_i          one-cycle trigger write
//   trigger_src_i      requester ID of the trigger
//   done_i             engine completion pulse
//   start_o            one-cycle engine start pulse
//   busy_o             at least one context pending or running
//   is_critical_o      offload lock is held
//   full_context_o     all contexts occupied
//   pointer_context_o  context being programmed
//   running_context_o  context executing or next to execute
//   true_done_o        one-cycle job-retired pulse
//   lock_owner_o       requester ID of the lock holder
// Configuration macro
//   HWPE_CTRL_LOCK_TIMEOUT_EN  when defined, an 8-bit counter releases the
//                              lock after 256 consecutive held cycles
//                              without an accepted trigger.
// ============================================================================
module hwpe_ctrl_ctx_scheduler #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned ID_WIDTH  = 16,
    localparam int unsigned CW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                acquire_i,
    input  logic [ID_WIDTH-1:0] acquire_src_i,
    input  logic                trigger_i,
    input  logic [ID_WIDTH-1:0] trigger_src_i,
    input  logic                done_i,
    output logic                start_o,
    output logic                busy_o,
    output logic                is_critical_o,
    output logic                full_context_o,
    output logic [CW-1:0]       pointer_context_o,
    output logic [CW-1:0]       running_context_o,
    output logic                true_done_o,
    output logic [ID_WIDTH-1:0] lock_owner_o
);

    // Occupancy needs to represent 0..N_CONTEXT inclusive.
    localparam int unsigned PW = $clog2(N_CONTEXT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_RETIRE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                lock_q, lock_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       run_q, run_d;
    logic [PW-1:0]       pend_q, pend_d;

    logic                full;
    logic                trig_ok;
    logic                acq_ok;
    logic                retire;
    logic                tmo_expire;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return (v == CW'(N_CONTEXT - 1)) ? '0 : v + CW'(1);
    endfunction

    assign full    = (pend_q == PW'(N_CONTEXT));
    assign retire  = (state_q == S_RETIRE);
    assign trig_ok = trigger_i && lock_q && (trigger_src_i == owner_q);
    // An owner trigger in the same cycle releases the lock, so the acquire
    // must not re-take it; the lock_q term already excludes that case.
    assign acq_ok  = acquire_i && !lock_q && !full && !trig_ok;

`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (acq_ok) begin
            tmo_d = '0;
        end else if (lock_q && !trig_ok) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    // tmo_q counts held cycles minus one; the 256th held cycle sees 255.
    assign tmo_expire = lock_q && !trig_ok && (tmo_q == 8'hFF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (clear_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_expire = 1'b0;
`endif

    // Lock, owner and programming pointer.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (trig_ok) begin
            lock_d = 1'b0;
            ptr_d  = wrap_inc(ptr_q);
        end else if (tmo_expire) begin
            lock_d = 1'b0;
        end else if (acq_ok) begin
            lock_d  = 1'b1;
            owner_d = acquire_src_i;
        end
    end

    // Occupancy: a commit and a retire in the same cycle cancel out.
    always_comb begin
        pend_d = pend_q;
        run_d  = run_q;
        if (trig_ok && !retire) begin
            pend_d = pend_q + PW'(1);
        end else if (!trig_ok && retire) begin
            pend_d = pend_q - PW'(1);
        end
        if (retire) begin
            run_d = wrap_inc(run_q);
        end
    end

    // Run FSM next state and outputs.
    always_comb begin
        state_d     = state_q;
        start_o     = 1'b0;
        true_done_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                start_o = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (done_i) begin
                    state_d = S_RETIRE;
                end
            end
            S_RETIRE: begin
                true_done_o = 1'b1;
                // Go straight to the next job if any remains after this one.
                state_d = (pend_d != '0) ? S_START : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            lock_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            run_q   <= '0;
            pend_q  <= '0;
        end else if (clear_i) begin
            state_q <= S_IDLE;
            lock_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            run_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            run_q   <= run_d;
            pend_q  <= pend_d;
        end
    end

    assign busy_o            = (pend_q != '0);
    assign full_context_o    = full;
    assign is_critical_o     = lock_q;
    assign lock_owner_o      = owner_q;
    assign pointer_context_o = ptr_q;
    assign running_context_o = run_q;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_ctrl_ctx_scheduler
// Description : Self-checking bench for hwpe_ctrl_ctx_scheduler. A job-level
//               reference model (occupancy count, lock, and the cycles at
//               which the next start / retire events are due) predicts every
//               output each cycle under directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl_ctx_scheduler;

    localparam int N  = 2;
    localparam int IW = 16;
    localparam int CW = 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          acquire_i = 1'b0;
    logic [IW-1:0] acquire_src_i = '0;
    logic          trigger_i = 1'b0;
    logic [IW-1:0] trigger_src_i = '0;
    logic          done_i = 1'b0;
    logic          start_o;
    logic          busy_o;
    logic          is_critical_o;
    logic          full_context_o;
    logic [CW-1:0] pointer_context_o;
    logic [CW-1:0] running_context_o;
    logic          true_done_o;
    logic [IW-1:0] lock_owner_o;

    hwpe_ctrl_ctx_scheduler #(
        .N_CONTEXT (N),
        .ID_WIDTH  (IW)
    ) u_dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .clear_i           (clear_i),
        .acquire_i         (acquire_i),
        .acquire_src_i     (acquire_src_i),
        .trigger_i         (trigger_i),
        .trigger_src_i     (trigger_src_i),
        .done_i            (done_i),
        .start_o           (start_o),
        .busy_o            (busy_o),
        .is_critical_o     (is_critical_o),
        .full_context_o    (full_context_o),
        .pointer_context_o (pointer_context_o),
        .running_context_o (running_context_o),
        .true_done_o       (true_done_o),
        .lock_owner_o      (lock_owner_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: jobs and lock at transaction level.
    int m_pend;       // committed jobs not yet retired
    int m_lock;
    int m_owner;
    int m_ptr;
    int m_run;
    int m_start_at;   // cycle at which start_o is due, -1 if none
    int m_started;    // cycle the current job started, -1 if none running
    int m_retire_at;  // cycle at which true_done_o is due, -1 if none
    int m_held;       // cycles the lock has been held

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_lock = 0; m_owner = 0; m_ptr = 0; m_run = 0;
        m_start_at = -1; m_started = -1; m_retire_at = -1; m_held = 0;
    endtask

    task automatic check_outputs();
        chk("start_o",     32'(start_o),           32'(m_start_at == cyc));
        chk("true_done_o", 32'(true_done_o),       32'(m_retire_at == cyc));
        chk("busy_o",      32'(busy_o),            32'(m_pend != 0));
        chk("full",        32'(full_context_o),    32'(m_pend == N));
        chk("is_critical", 32'(is_critical_o),     32'(m_lock));
        chk("pointer",     32'(pointer_context_o), 32'(m_ptr));
        chk("running",     32'(running_context_o), 32'(m_run));
        if (m_lock != 0) begin
            chk("owner", 32'(lock_owner_o), 32'(m_owner));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check.
    task automatic step(input bit acq, input int asrc, input bit trg, input int tsrc,
                        input bit dn, input bit clr);
        bit trig_ok, acq_ok, retiring;
        int newpend;
        acquire_i     = acq;
        acquire_src_i = IW'(asrc);
        trigger_i     = trg;
        trigger_src_i = IW'(tsrc);
        done_i        = dn;
        clear_i       = clr;
        @(posedge clk_i);
        if (clr) begin
            model_reset();
        end else begin
            trig_ok  = trg && (m_lock != 0) && (tsrc == m_owner);
            acq_ok   = acq && (m_lock == 0) && (m_pend != N) && !trig_ok;
            retiring = (m_retire_at == cyc);
            if (m_start_at == cyc) begin
                m_started  = cyc;
                m_start_at = -1;
            end else if (m_started >= 0 && cyc > m_started && dn) begin
                m_started   = -1;
                m_retire_at = cyc + 1;
            end
            newpend = m_pend + int'(trig_ok) - int'(retiring);
            if (retiring) begin
                m_run       = (m_run + 1) % N;
                m_retire_at = -1;
                if (newpend > 0) m_start_at = cyc + 1;
            end else if (m_start_at < 0 && m_started < 0 && m_retire_at < 0 && newpend > 0) begin
                // Engine idle: it notices the new job one cycle later.
                m_start_at = cyc + 2;
            end
            if (trig_ok) begin
                m_ptr  = (m_ptr + 1) % N;
                m_lock = 0;
            end else if (m_lock != 0) begin
                m_held++;
`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
                if (m_held == 256) m_lock = 0;
`endif
            end
            if (acq_ok) begin
                m_lock  = 1;
                m_owner = asrc;
                m_held  = 0;
            end
            m_pend = newpend;
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_outputs();

        // Single job from requester 3, done ten cycles after the trigger.
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        idle(9);
        step(0, 0, 0, 0, 1, 0);
        idle(3);

        // Contention: second acquire and non-owner trigger ignored.
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        idle(2);
        step(0, 0, 1, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0);
        idle(3);

        // Full: two jobs queued, a third acquire ignored; back-to-back retire.
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0);
        idle(3);

        // Trigger accepted in the retire cycle; simultaneous acquire+trigger.
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        idle(3);
        step(1, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 6, 1, 6, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0);
        idle(3);

        // Clear mid-run with two jobs pending, then a stale done.
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        idle(3);

`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
        step(1, 7, 0, 0, 0, 0);
        idle(260);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit acq, trg, dn, clr;
            int asrc, tsrc;
            acq  = ($urandom_range(0, 99) < 30);
            trg  = ($urandom_range(0, 99) < 30);
            dn   = ($urandom_range(0, 99) < 15);
            clr  = ($urandom_range(0, 999) < 8);
            asrc = $urandom_range(1, 3);
            tsrc = ($urandom_range(0, 1) != 0) ? m_owner : $urandom_range(1, 3);
            step(acq, asrc, trg, tsrc, dn, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
